branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised successor to the single-cycle branch resolver for the ButterFly RV32IM core. It combines a direct-mapped branch history table (2-bit saturating counters) and a branch target buffer, giving fetch-stage predictions. It also resolves conditional branches in execute, flags mispredictions with a registered redirect, and trains the tables. The block sits between IF, where prediction is looked up, and EX, where branches are resolved and trained.

## Interface
- `XLEN`, 32, datapath/PC width
- `BP_ENTRIES`, 64, table depth; power of two, ≥ 4; `IDX_W = $clog2(BP_ENTRIES)`
- `clk_i`  in  1  core clock
- `rst_i`  in  1  reset; one clock domain; reset is asynchronous and active-high
- `flush_i`  in  1  kills any prediction being registered this cycle
- `pred_req_i`  in  1  fetch lookup request
- `pred_pc_i`  in  XLEN  fetch PC
- `pred_valid_o`  out  1  prediction valid (one cycle after request)
- `pred_taken_o`  out  1  predicted taken
- `pred_target_o`  out  XLEN  predicted next PC
- `res_valid_i`  in  1  conditional branch resolving in EX
- `res_pc_i`, `res_rs1_i`, `res_rs2_i`, `res_imm_i`  in  XLEN  branch PC, operands, B-immediate
- `res_type_i`  in  3  `br_type_e` (funct3 encoding)
- `res_pred_taken_i`  in  1  prediction carried down the pipe
- `res_pred_target_i`  in  XLEN  predicted next PC carried down the pipe
- `mispredict_o`  out  1  one-cycle redirect pulse
- `redirect_pc_o`  out  XLEN  correct next PC, valid with `mispredict_o`
- `stat_branches_o`, `stat_mispred_o`  out  32  statistics counters (see Configuration)

## Operation
- Index is `pc[IDX_W+1:2]`. Tag is `pc[XLEN-1:IDX_W+2]`. Each entry holds `valid`, `tag`, `target`, and a 2-bit `ctr`.
- Lookup: a hit requires valid AND tag match. Predict taken only when hit AND `ctr[1]`.
  - Taken prediction: `pred_target = target`.
  - Otherwise: `pred_target = pred_pc + 4` (mod 2^XLEN).
- Resolve condition, per `br_type_e`:
  - BEQ=000: rs1 == rs2
  - BNE=001: rs1 != rs2
  - BLT=100: signed <
  - BGE=101: signed ≥
  - BLTU=110: unsigned <
  - BGEU=111: unsigned ≥
  - Codes 010 and 011: treated as not-taken; mispredict is still evaluated; tables are not trained.
- Actual next PC is `pc + imm` if taken, else `pc + 4`. Additions wrap modulo 2^XLEN.
- Mispredict condition: `actual_taken != res_pred_taken_i`, OR (`actual_taken` AND `res_pred_target_i != pc+imm`).
- Training on a resolve with tag hit:
  - Taken: `ctr` saturating-increments, max 11; `target` is rewritten.
  - Not taken: `ctr` saturating-decrements, min 00.
- Training on a resolve with tag miss:
  - Taken: allocate (valid=1, new tag, target, `ctr`=10).
  - Not taken: no change.

## Timing
- Prediction latency is 1 cycle. `pred_*_o` are registered from the request cycle.
- `pred_valid_o = pred_req_i & ~flush_i` of the previous cycle. If `flush_i` is asserted in the response cycle, `pred_valid_o` is forced to 0.
- Resolve latency is 1 cycle. `mispredict_o` and `redirect_pc_o` are registered and pulse for exactly one cycle per mispredicted resolve.
- Table write takes effect at the clock edge ending the resolve cycle.
- A same-cycle lookup and train to the same index returns the pre-update (old) entry. The new value is visible to a lookup issued the following cycle.
- Back-to-back resolves are supported every cycle.
- Reset values:
  - All `valid` = 0 and all `ctr` = 01.
  - All outputs = 0, including `pred_target_o` and `redirect_pc_o`.
  - Statistics counters = 0.
- Reset asserted mid-operation discards any pending registered prediction or redirect immediately.
- `flush_i` does not affect resolve or training.

## Configuration
- Macro: `BUTTERFLY_BP_STATS_EN`.
- Defined: `stat_branches_o` increments on every `res_valid_i` cycle. `stat_mispred_o` increments on every cycle in which a mispredict is registered. Both wrap at 2^32.
- Undefined: no counter flops are built, and both ports are tied to 0.

## Structure
- `butterfly_pkg` holds:
  - `br_type_e`, with the encodings above
  - `BP_CTR_RESET` = 2'b01
  - `BP_CTR_ALLOC` = 2'b10
  - a `bp_entry_t` struct (valid/tag/target/ctr), parameterised via the `XLEN`/`IDX_W` localparams
- One sub-module, `branch_cond`: purely combinational (rs1, rs2, type → taken). It is reused by EX for any later non-predicted path.

## Test plan
- Reset, then lookup PC 0x100 → `pred_valid_o`=1 next cycle, `pred_taken_o`=0, `pred_target_o`=0x104.
- Resolve BEQ at 0x100: rs1=rs2=5, imm=0x40, pred_taken=0 → `mispredict_o` pulses one cycle with `redirect_pc_o`=0x140. A lookup of 0x100 two cycles later predicts taken (`ctr`=10) with target 0x140.
- Train the same branch not-taken twice from `ctr`=11 → predicts not-taken (`ctr`=01). Three more not-taken resolves hold `ctr` at 00, and no mispredict is flagged when pred_taken=0.
- Signed vs unsigned: rs1=0xFFFFFFFF, rs2=1 → BLT taken, BLTU not taken. Also pc=0xFFFFFFFC not taken → redirect 0x00000000 (wrap).
- Aliasing: PCs 0x100 and 0x100 + 4·BP_ENTRIES, second one resolved taken → the entry is replaced. Simultaneous lookup of 0x100 in the write cycle returns the old entry.
- With `BUTTERFLY_BP_STATS_EN`: 10 resolves, 3 mispredicted → `stat_branches_o`=10, `stat_mispred_o`=3. Asserting `rst_i` mid-sequence zeroes both counters asynchronously.

Source files
------------

// File: rtl/butterfly_pkg.sv
// butterfly_pkg: shared types and constants for the ButterFly branch
// prediction unit.
//   br_type_e     : conditional-branch type, in funct3 encoding
//   BP_CTR_RESET  : counter value after reset (weakly not-taken)
//   BP_CTR_ALLOC  : counter value given to a newly allocated entry (weakly taken)
//   bp_entry_t    : one table entry for the default geometry
package butterfly_pkg;

  localparam int XLEN       = 32;
  localparam int BP_ENTRIES = 64;
  localparam int IDX_W      = $clog2(BP_ENTRIES);
  localparam int TAG_W      = XLEN - IDX_W - 2;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_type_e;

  localparam logic [1:0] BP_CTR_RESET = 2'b01;
  localparam logic [1:0] BP_CTR_ALLOC = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [1:0]       ctr;
  } bp_entry_t;

endpackage

// File: rtl/branch_cond.sv
// branch_cond: purely combinational conditional-branch evaluator.
// Ports:
//   rs1, rs2  in  XLEN  source operands
//   br_type   in  3     branch type (funct3); 010/011 evaluate as not taken
//   taken     out 1     branch condition holds
module branch_cond #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      br_type,
  output logic            taken
);
  import butterfly_pkg::BR_BEQ;
  import butterfly_pkg::BR_BNE;
  import butterfly_pkg::BR_BLT;
  import butterfly_pkg::BR_BGE;
  import butterfly_pkg::BR_BLTU;
  import butterfly_pkg::BR_BGEU;

  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_BEQ:  taken = (rs1 == rs2);
      BR_BNE:  taken = (rs1 != rs2);
      BR_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      BR_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      BR_BLTU: taken = (rs1 <  rs2);
      BR_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BHT (2-bit counters) + BTB giving
// fetch-stage predictions, with execute-stage branch resolution, a
// registered misprediction redirect and table training.
// Ports:
//   clk_i, rst_i (async, active-high), flush_i
//   pred_req_i / pred_pc_i                   -> fetch lookup request
//   pred_valid_o / pred_taken_o / pred_target_o <- prediction, 1 cycle later
//   res_valid_i, res_pc_i, res_rs1_i, res_rs2_i, res_imm_i, res_type_i,
//   res_pred_taken_i, res_pred_target_i      -> branch resolving in EX
//   mispredict_o / redirect_pc_o             <- registered redirect pulse
//   stat_branches_o / stat_mispred_o         <- counters, only built when
//                                               BUTTERFLY_BP_STATS_EN is defined
module branch_predict_unit #(
  parameter int XLEN       = 32,
  parameter int BP_ENTRIES = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            pred_req_i,
  input  logic [XLEN-1:0] pred_pc_i,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            res_valid_i,
  input  logic [XLEN-1:0] res_pc_i,
  input  logic [XLEN-1:0] res_rs1_i,
  input  logic [XLEN-1:0] res_rs2_i,
  input  logic [XLEN-1:0] res_imm_i,
  input  logic [2:0]      res_type_i,
  input  logic            res_pred_taken_i,
  input  logic [XLEN-1:0] res_pred_target_i,
  output logic            mispredict_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [31:0]     stat_branches_o,
  output logic [31:0]     stat_mispred_o
);
  import butterfly_pkg::BP_CTR_RESET;
  import butterfly_pkg::BP_CTR_ALLOC;

  localparam int IDX_W = $clog2(BP_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic             valid_reg  [BP_ENTRIES];
  logic [1:0]       ctr_reg    [BP_ENTRIES];
  logic [TAG_W-1:0] tag_reg    [BP_ENTRIES];
  logic [XLEN-1:0]  target_reg [BP_ENTRIES];

  // ---------------- lookup ----------------
  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             look_hit;
  logic             look_taken;
  logic [XLEN-1:0]  look_target;

  assign look_idx    = pred_pc_i[IDX_W+1:2];
  assign look_tag    = pred_pc_i[XLEN-1:IDX_W+2];
  assign look_hit    = valid_reg[look_idx] && (tag_reg[look_idx] == look_tag);
  assign look_taken  = look_hit && ctr_reg[look_idx][1];
  assign look_target = look_taken ? target_reg[look_idx] : pred_pc_i + XLEN'(4);

  logic            pred_valid_reg;
  logic            pred_taken_reg;
  logic [XLEN-1:0] pred_target_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pred_valid_reg  <= 1'b0;
      pred_taken_reg  <= 1'b0;
      pred_target_reg <= '0;
    end else begin
      pred_valid_reg <= pred_req_i & ~flush_i;
      if (pred_req_i) begin
        pred_taken_reg  <= look_taken;
        pred_target_reg <= look_target;
      end
    end
  end

  // A flush in the response cycle still has to kill the prediction.
  assign pred_valid_o  = pred_valid_reg & ~flush_i;
  assign pred_taken_o  = pred_taken_reg;
  assign pred_target_o = pred_target_reg;

  // ---------------- resolve ----------------
  logic             cond_taken;
  logic             trains;
  logic [XLEN-1:0]  taken_pc;
  logic [XLEN-1:0]  actual_next;
  logic             mispredict_next;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .rs1     (res_rs1_i),
    .rs2     (res_rs2_i),
    .br_type (res_type_i),
    .taken   (cond_taken)
  );

  // Codes 010/011 are not real branches: evaluated as not taken, never trained.
  assign trains      = (res_type_i != 3'b010) && (res_type_i != 3'b011);
  assign taken_pc    = res_pc_i + res_imm_i;
  assign actual_next = cond_taken ? taken_pc : res_pc_i + XLEN'(4);
  assign mispredict_next = (cond_taken != res_pred_taken_i) ||
                           (cond_taken && (res_pred_target_i != taken_pc));

  logic            mispredict_reg;
  logic [XLEN-1:0] redirect_pc_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mispredict_reg  <= 1'b0;
      redirect_pc_reg <= '0;
    end else begin
      mispredict_reg <= res_valid_i & mispredict_next;
      if (res_valid_i && mispredict_next)
        redirect_pc_reg <= actual_next;
    end
  end

  assign mispredict_o  = mispredict_reg;
  assign redirect_pc_o = redirect_pc_reg;

  // ---------------- training ----------------
  logic [IDX_W-1:0] res_idx;
  logic [TAG_W-1:0] res_tag;
  logic             res_hit;
  logic             ctr_wr;
  logic             tgt_wr;
  logic [1:0]       ctr_next;

  assign res_idx = res_pc_i[IDX_W+1:2];
  assign res_tag = res_pc_i[XLEN-1:IDX_W+2];
  assign res_hit = valid_reg[res_idx] && (tag_reg[res_idx] == res_tag);
  // A miss only allocates when taken; not-taken misses leave the table alone.
  assign ctr_wr  = res_valid_i && trains && (res_hit || cond_taken);
  assign tgt_wr  = res_valid_i && trains && cond_taken;

  always_comb begin
    ctr_next = ctr_reg[res_idx];
    if (!res_hit)
      ctr_next = BP_CTR_ALLOC;
    else if (cond_taken)
      ctr_next = (ctr_reg[res_idx] == 2'b11) ? 2'b11 : ctr_reg[res_idx] + 2'd1;
    else
      ctr_next = (ctr_reg[res_idx] == 2'b00) ? 2'b00 : ctr_reg[res_idx] - 2'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BP_ENTRIES; i++) begin
        valid_reg[i] <= 1'b0;
        ctr_reg[i]   <= BP_CTR_RESET;
      end
    end else if (ctr_wr) begin
      valid_reg[res_idx] <= 1'b1;
      ctr_reg[res_idx]   <= ctr_next;
    end
  end

  // Tag/target need no reset: valid_reg gates every use.
  always_ff @(posedge clk_i) begin
    if (tgt_wr) begin
      tag_reg[res_idx]    <= res_tag;
      target_reg[res_idx] <= taken_pc;
    end
  end

  // Low PC bits are always zero for aligned fetch and never index the tables.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc_i[1:0], res_pc_i[1:0]};

  // ---------------- statistics ----------------
`ifdef BUTTERFLY_BP_STATS_EN
  logic [31:0] stat_branches_reg;
  logic [31:0] stat_mispred_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_branches_reg <= '0;
      stat_mispred_reg  <= '0;
    end else begin
      if (res_valid_i)
        stat_branches_reg <= stat_branches_reg + 32'd1;
      if (res_valid_i && mispredict_next)
        stat_mispred_reg <= stat_mispred_reg + 32'd1;
    end
  end

  assign stat_branches_o = stat_branches_reg;
  assign stat_mispred_o  = stat_mispred_reg;
`else
  assign stat_branches_o = '0;
  assign stat_mispred_o  = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: a table of resolve vectors
// plus hand-written sequences for prediction, training, aliasing, flush and
// reset behaviour. Honours BUTTERFLY_BP_STATS_EN for the counter checks.
module tb_branch_predict_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        pred_req;
  logic [31:0] pred_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [31:0] res_pc, res_rs1, res_rs2, res_imm;
  logic [2:0]  res_type;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches, stat_mispred;

  int checks   = 0;
  int failures = 0;

  branch_predict_unit #(.XLEN(32), .BP_ENTRIES(64)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .flush_i           (flush),
    .pred_req_i        (pred_req),
    .pred_pc_i         (pred_pc),
    .pred_valid_o      (pred_valid),
    .pred_taken_o      (pred_taken),
    .pred_target_o     (pred_target),
    .res_valid_i       (res_valid),
    .res_pc_i          (res_pc),
    .res_rs1_i         (res_rs1),
    .res_rs2_i         (res_rs2),
    .res_imm_i         (res_imm),
    .res_type_i        (res_type),
    .res_pred_taken_i  (res_pred_taken),
    .res_pred_target_i (res_pred_target),
    .mispredict_o      (mispredict),
    .redirect_pc_o     (redirect_pc),
    .stat_branches_o   (stat_branches),
    .stat_mispred_o    (stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  br_type;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pt;
    logic [31:0] ptgt;
    logic        exp_mis;
    logic [31:0] exp_redir;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ptgt);
    res_valid       = 1'b1;
    res_type        = t;
    res_rs1         = a;
    res_rs2         = b;
    res_pc          = pc;
    res_imm         = imm;
    res_pred_taken  = pt;
    res_pred_target = ptgt;
  endtask

  task automatic lookup(input logic [31:0] pc);
    pred_req = 1'b1;
    pred_pc  = pc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; pred_req = 1'b0; pred_pc = '0;
    res_valid = 1'b0; res_pc = '0; res_rs1 = '0; res_rs2 = '0; res_imm = '0;
    res_type = 3'b000; res_pred_taken = 1'b0; res_pred_target = '0;

    //                type     rs1           rs2           pc            imm           pt  ptgt          mis redirect
    vecs[0]  = '{3'b000, 32'd5,        32'd5,        32'h0000_1000, 32'h40,       1'b0, 32'h0,         1'b1, 32'h0000_1040};
    vecs[1]  = '{3'b001, 32'd5,        32'd5,        32'h0000_1004, 32'h10,       1'b0, 32'h0,         1'b0, 32'h0};
    vecs[2]  = '{3'b100, 32'hFFFF_FFFF, 32'd1,       32'h0000_1008, 32'h20,       1'b0, 32'h0,         1'b1, 32'h0000_1028};
    vecs[3]  = '{3'b110, 32'hFFFF_FFFF, 32'd1,       32'h0000_100C, 32'h20,       1'b1, 32'h0000_102C, 1'b1, 32'h0000_1010};
    vecs[4]  = '{3'b101, 32'd1,        32'hFFFF_FFFF, 32'h0000_1010, 32'h8,       1'b1, 32'h0000_1018, 1'b0, 32'h0};
    vecs[5]  = '{3'b111, 32'd1,        32'hFFFF_FFFF, 32'h0000_1014, 32'h8,       1'b0, 32'h0,         1'b0, 32'h0};
    vecs[6]  = '{3'b101, 32'd3,        32'd3,        32'h0000_1018, 32'h100,      1'b1, 32'h0000_2000, 1'b1, 32'h0000_1118};
    vecs[7]  = '{3'b010, 32'd7,        32'd7,        32'h0000_101C, 32'h40,       1'b1, 32'h0000_2000, 1'b1, 32'h0000_1020};
    vecs[8]  = '{3'b000, 32'd1,        32'd2,        32'hFFFF_FFFC, 32'h10,       1'b1, 32'h0000_000C, 1'b1, 32'h0000_0000};
    vecs[9]  = '{3'b110, 32'd0,        32'hFFFF_FFFF, 32'h0000_1020, 32'hFFFF_FFF0, 1'b0, 32'h0,       1'b1, 32'h0000_1010};
    vecs[10] = '{3'b011, 32'd1,        32'd2,        32'h0000_1024, 32'h40,       1'b0, 32'h0,         1'b0, 32'h0};

    // ---- reset state ----
    #12;
    chk("rst_pred_valid",  {31'd0, pred_valid},  32'd0);
    chk("rst_pred_taken",  {31'd0, pred_taken},  32'd0);
    chk("rst_pred_target", pred_target,          32'd0);
    chk("rst_mispredict",  {31'd0, mispredict},  32'd0);
    chk("rst_redirect",    redirect_pc,          32'd0);
    chk("rst_stat_br",     stat_branches,        32'd0);
    chk("rst_stat_mis",    stat_mispred,         32'd0);
    rst = 1'b0;
    tick();

    // ---- cold lookup of 0x100 ----
    lookup(32'h100);
    tick();
    pred_req = 1'b0;
    chk("cold_valid",  {31'd0, pred_valid}, 32'd1);
    chk("cold_taken",  {31'd0, pred_taken}, 32'd0);
    chk("cold_target", pred_target,         32'h104);
    $display("txn lookup 0x100 cold: valid=%0d taken=%0d target=0x%08h", pred_valid, pred_taken, pred_target);

    // ---- first taken resolve allocates with ctr=10 ----
    resolve(3'b000, 32'd5, 32'd5, 32'h100, 32'h40, 1'b0, 32'h0);
    tick();
    res_valid = 1'b0;
    chk("alloc_mispred",  {31'd0, mispredict}, 32'd1);
    chk("alloc_redirect", redirect_pc,         32'h140);
    $display("txn resolve BEQ 0x100 taken: mispredict=%0d redirect=0x%08h", mispredict, redirect_pc);
    tick();
    chk("alloc_pulse_end", {31'd0, mispredict}, 32'd0);
    lookup(32'h100);
    tick();
    pred_req = 1'b0;
    chk("alloc_pred_taken",  {31'd0, pred_taken}, 32'd1);
    chk("alloc_pred_target", pred_target,         32'h140);
    $display("txn lookup 0x100 trained: taken=%0d target=0x%08h", pred_taken, pred_target);

    // ---- flush on request cycle and on response cycle ----
    lookup(32'h100); flush = 1'b1;
    tick();
    pred_req = 1'b0; flush = 1'b0;
    chk("flush_req_valid", {31'd0, pred_valid}, 32'd0);
    lookup(32'h100);
    tick();
    pred_req = 1'b0; flush = 1'b1;
    #1;
    chk("flush_resp_valid", {31'd0, pred_valid}, 32'd0);
    flush = 1'b0;
    #1;
    chk("noflush_resp_valid", {31'd0, pred_valid}, 32'd1);
    $display("txn flush checks done");

    // ---- saturate up to 11, then two not-taken -> 01 ----
    resolve(3'b000, 32'd5, 32'd5, 32'h100, 32'h40, 1'b1, 32'h140);
    tick();
    chk("correct_taken_no_mis", {31'd0, mispredict}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      resolve(3'b000, 32'd5, 32'd6, 32'h100, 32'h40, 1'b1, 32'h140);
      tick();
      chk("nt_mis",      {31'd0, mispredict}, 32'd1);
      chk("nt_redirect", redirect_pc,         32'h104);
      $display("txn resolve BEQ 0x100 not-taken #%0d: mispredict=%0d", i, mispredict);
    end
    res_valid = 1'b0;
    lookup(32'h100);
    tick();
    pred_req = 1'b0;
    chk("ctr01_taken",  {31'd0, pred_taken}, 32'd0);
    chk("ctr01_target", pred_target,         32'h104);

    // ---- three more not-taken hold at 00, no mispredict ----
    for (int i = 0; i < 3; i++) begin
      resolve(3'b000, 32'd5, 32'd6, 32'h100, 32'h40, 1'b0, 32'h0);
      tick();
      chk("sat_low_no_mis", {31'd0, mispredict}, 32'd0);
    end
    // One taken from 00 gives 01: still predicts not taken.
    resolve(3'b000, 32'd5, 32'd5, 32'h100, 32'h40, 1'b0, 32'h0);
    tick();
    res_valid = 1'b0;
    lookup(32'h100);
    tick();
    pred_req = 1'b0;
    chk("ctr00_then_taken", {31'd0, pred_taken}, 32'd0);
    $display("txn counter floor check: taken=%0d", pred_taken);

    // ---- bring 0x100 back to ctr=10, then alias with 0x200 ----
    resolve(3'b000, 32'd5, 32'd5, 32'h100, 32'h40, 1'b0, 32'h0);
    tick();
    resolve(3'b000, 32'd9, 32'd9, 32'h200, 32'h80, 1'b0, 32'h0);
    lookup(32'h100);
    tick();
    res_valid = 1'b0;
    chk("alias_old_taken",  {31'd0, pred_taken}, 32'd1);
    chk("alias_old_target", pred_target,         32'h140);
    lookup(32'h100);
    tick();
    chk("alias_evicted_taken",  {31'd0, pred_taken}, 32'd0);
    chk("alias_evicted_target", pred_target,         32'h104);
    lookup(32'h200);
    tick();
    pred_req = 1'b0;
    chk("alias_new_taken",  {31'd0, pred_taken}, 32'd1);
    chk("alias_new_target", pred_target,         32'h280);
    $display("txn alias 0x200: taken=%0d target=0x%08h", pred_taken, pred_target);

    // ---- table-driven resolve vectors, back to back ----
    for (int v = 0; v < 11; v++) begin
      resolve(vecs[v].br_type, vecs[v].rs1, vecs[v].rs2, vecs[v].pc, vecs[v].imm,
              vecs[v].pt, vecs[v].ptgt);
      tick();
      chk($sformatf("vec%0d_mis", v), {31'd0, mispredict}, {31'd0, vecs[v].exp_mis});
      if (vecs[v].exp_mis)
        chk($sformatf("vec%0d_redirect", v), redirect_pc, vecs[v].exp_redir);
      $display("txn vec %0d type=%03b pc=0x%08h: mispredict=%0d redirect=0x%08h",
               v, vecs[v].br_type, vecs[v].pc, mispredict, redirect_pc);
    end
    res_valid = 1'b0;

    // ---- async reset discards a pending redirect ----
    resolve(3'b000, 32'd1, 32'd1, 32'h300, 32'h40, 1'b0, 32'h0);
    lookup(32'h200);
    tick();
    res_valid = 1'b0; pred_req = 1'b0;
    chk("pre_rst_mis", {31'd0, mispredict}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mis",      {31'd0, mispredict}, 32'd0);
    chk("async_rst_redirect", redirect_pc,         32'd0);
    chk("async_rst_valid",    {31'd0, pred_valid}, 32'd0);
    chk("async_rst_target",   pred_target,         32'd0);
    chk("async_rst_stat_br",  stat_branches,       32'd0);
    chk("async_rst_stat_mis", stat_mispred,        32'd0);
    #3 rst = 1'b0;
    tick();
    // Table was cleared too: 0x200 no longer predicted taken.
    lookup(32'h200);
    tick();
    pred_req = 1'b0;
    chk("post_rst_taken", {31'd0, pred_taken}, 32'd0);

    // ---- statistics: 10 resolves, 3 mispredicted ----
    for (int i = 0; i < 10; i++) begin
      if (i < 3) resolve(3'b000, 32'd4, 32'd4, 32'h400 + 32'(i * 4), 32'h20, 1'b0, 32'h0);
      else       resolve(3'b000, 32'd4, 32'd5, 32'h400 + 32'(i * 4), 32'h20, 1'b0, 32'h0);
      tick();
    end
    res_valid = 1'b0;
    tick();
`ifdef BUTTERFLY_BP_STATS_EN
    chk("stat_branches", stat_branches, 32'd10);
    chk("stat_mispred",  stat_mispred,  32'd3);
`else
    chk("stat_branches_tied", stat_branches, 32'd0);
    chk("stat_mispred_tied",  stat_mispred,  32'd0);
`endif
    $display("txn stats: branches=%0d mispred=%0d", stat_branches, stat_mispred);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
